// File: rtl/xalulite_acc.sv
// xalulite_acc: two-operand ALU over a selectable N_SRC flow bus, with feedback accumulation.
// Latency: 2 cycles from in_valid to out_valid; one accepted sample per cycle.
// Backpressure: none. Samples are taken whenever running; out_valid is a 1-cycle pulse.
// Build option: define ALULITE_ACC_SAT_EN for saturating ADD/SUB and a sticky overflow flag.
module xalulite_acc #(
  parameter  int DATA_W = 32,
  parameter  int N_SRC  = 16,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_SRC*DATA_W-1:0] flow_in,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sela,
  input  logic [SEL_W-1:0]        selb,
  input  logic [3:0]              fns,
  input  logic                    self_loop,
  input  logic [CNT_W-1:0]        acc_len,
  output logic [DATA_W-1:0]       flow_out,
  output logic                    out_valid,
  output logic                    overflow
);

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_CMP = 4'd5;
  localparam logic [3:0] FN_MAX = 4'd6;
  localparam logic [3:0] FN_MIN = 4'd7;
  localparam logic [3:0] FN_MUX = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              cfg_load, flush, accept, s2_fire;

  logic [SEL_W-1:0]  sela_q, selb_q;
  logic [3:0]        fns_q;
  logic              self_loop_q;
  logic [CNT_W-1:0]  acc_len_q;

  logic [DATA_W-1:0] src_a, src_b;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              v1_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a_int, add_res, sub_res, alu_res, result;
  logic [DATA_W:0]   diff;
  logic              lt, seed, last, deliver;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus per-cycle control strobes; leaving RUN flushes the pipe
  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    flush    = 1'b0;
    accept   = 1'b0;
    s2_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d  = RUN;
          cfg_load = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else begin
          accept  = in_valid;
          s2_fire = v1_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration is frozen for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sela_q      <= '0;
      selb_q      <= '0;
      fns_q       <= '0;
      self_loop_q <= 1'b0;
      acc_len_q   <= '0;
    end else if (cfg_load) begin
      sela_q      <= sela;
      selb_q      <= selb;
      fns_q       <= fns;
      self_loop_q <= self_loop;
      acc_len_q   <= acc_len;
    end
  end

  // Operand select; an index beyond N_SRC reads as zero
  always_comb begin
    src_a = '0;
    src_b = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sela_q == SEL_W'(k)) src_a = flow_in[k*DATA_W +: DATA_W];
      if (selb_q == SEL_W'(k)) src_b = flow_in[k*DATA_W +: DATA_W];
    end
  end

  // Stage 1: capture operands for each accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        op_a_q <= src_a;
        op_b_q <= src_b;
      end
    end
  end

  // Feedback operand and the exact (DATA_W+1)-bit b-a shared by SUB and the signed compares
  assign op_a_int = self_loop_q ? flow_out : op_a_q;
  assign diff     = {op_b_q[DATA_W-1], op_b_q} - {op_a_int[DATA_W-1], op_a_int};
  assign lt       = diff[DATA_W];
  assign seed     = self_loop_q && (cnt_q == '0);

`ifdef ALULITE_ACC_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W:0] sum;
  logic            add_ovf, sub_ovf, sat_hit, ovf_q;

  // Saturating ADD/SUB: a disagreeing top pair of bits in the widened result means overflow
  always_comb begin
    sum     = {op_a_int[DATA_W-1], op_a_int} + {op_b_q[DATA_W-1], op_b_q};
    add_ovf = sum[DATA_W] ^ sum[DATA_W-1];
    sub_ovf = diff[DATA_W] ^ diff[DATA_W-1];
    add_res = add_ovf ? (sum[DATA_W] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];
    sub_res = sub_ovf ? (diff[DATA_W] ? SAT_MIN : SAT_MAX) : diff[DATA_W-1:0];
    sat_hit = !seed && (((fns_q == FN_ADD) && add_ovf) || ((fns_q == FN_SUB) && sub_ovf));
  end

  // Sticky overflow, cleared only by reset or returning to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (flush)              ovf_q <= 1'b0;
    else if (s2_fire && sat_hit) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  // Wrapping ADD/SUB
  always_comb begin
    add_res = op_a_int + op_b_q;
    sub_res = diff[DATA_W-1:0];
  end

  assign overflow = 1'b0;
`endif

  // Function decode, window seeding and window-end detection
  always_comb begin
    case (fns_q)
      FN_ADD:  alu_res = add_res;
      FN_SUB:  alu_res = sub_res;
      FN_AND:  alu_res = op_a_int & op_b_q;
      FN_OR:   alu_res = op_a_int | op_b_q;
      FN_XOR:  alu_res = op_a_int ^ op_b_q;
      FN_CMP:  alu_res = {lt, diff[DATA_W-2:0]};
      FN_MAX:  alu_res = lt ? op_a_int : op_b_q;
      FN_MIN:  alu_res = lt ? op_b_q : op_a_int;
      FN_MUX:  alu_res = op_a_q[DATA_W-1] ? op_b_q : (self_loop_q ? flow_out : '0);
      default: alu_res = op_b_q;
    endcase
    result  = seed ? op_b_q : alu_res;
    last    = (acc_len_q != '0) && (cnt_q == acc_len_q - CNT_W'(1));
    deliver = !self_loop_q || (acc_len_q == '0) || last;
    cnt_d   = cnt_q;
    if (self_loop_q) begin
      // An unbounded window parks the counter at 1 so only the first sample seeds
      if (acc_len_q == '0) cnt_d = CNT_W'(1);
      else if (last)       cnt_d = '0;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage 2: result register, window counter and delivery pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flow_out  <= '0;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_valid <= s2_fire && deliver;
      if (s2_fire) begin
        flow_out <= result;
        cnt_q    <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_xalulite_acc.sv
// Testbench for xalulite_acc: directed vector table, multi-cycle corner sequences,
// and randomized runs scored against a sample-level reference model.
module tb_xalulite_acc;
  localparam int DATA_W = 32;
  localparam int N_SRC  = 16;
  localparam int CNT_W  = 16;
  localparam int SEL_W  = 4;

`ifdef ALULITE_ACC_SAT_EN
  localparam logic [31:0] OVF_SUM  = 32'h7FFF_FFFF;
  localparam logic        OVF_FLAG = 1'b1;
`else
  localparam logic [31:0] OVF_SUM  = 32'h8000_0000;
  localparam logic        OVF_FLAG = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic [N_SRC*DATA_W-1:0] flow_in = '0;
  logic                    in_valid = 1'b0;
  logic [SEL_W-1:0]        sela = '0;
  logic [SEL_W-1:0]        selb = '0;
  logic [3:0]              fns = '0;
  logic                    self_loop = 1'b0;
  logic [CNT_W-1:0]        acc_len = '0;
  logic [DATA_W-1:0]       flow_out;
  logic                    out_valid;
  logic                    overflow;

  always #5 clk = ~clk;

  xalulite_acc #(.DATA_W(DATA_W), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flow_in(flow_in), .in_valid(in_valid),
    .sela(sela), .selb(selb), .fns(fns), .self_loop(self_loop), .acc_len(acc_len),
    .flow_out(flow_out), .out_valid(out_valid), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Pulse monitor for the hand-written sequences
  int          pulses = 0;
  logic [31:0] last_val = '0;
  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      last_val = flow_out;
    end
  end

  typedef struct {
    logic [3:0]  f;
    int          sa;
    int          sb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic        vld;
    logic [31:0] val;
    logic        sat;
  } exp_t;

  vec_t        vecs[13];
  exp_t        q[$];
  logic [31:0] m_flow, m_vis;
  logic        m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    flow_in[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic start_run(input logic [3:0] f, input int sa, input int sb,
                           input logic sl, input logic [15:0] al);
    en = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    fns = f;
    sela = SEL_W'(sa);
    selb = SEL_W'(sb);
    self_loop = sl;
    acc_len = al;
    en = 1'b1;
    step();
  endtask

  task automatic push(input logic [31:0] b);
    set_src(7, b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  // Reference ALU from the function-code rules, using wide signed arithmetic
  function automatic logic [31:0] ref_op(input logic [3:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] areg,
                                         input logic sl, input logic [31:0] fo,
                                         output logic sat);
    longint      sa, sb, s;
    logic [31:0] d;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sat = 1'b0;
    d   = b - a;
    case (f)
      4'd0, 4'd1: begin
        s = (f == 4'd0) ? sa + sb : sb - sa;
`ifdef ALULITE_ACC_SAT_EN
        if (s > 64'sd2147483647) begin
          sat = 1'b1;
          s = 64'sd2147483647;
        end else if (s < -64'sd2147483648) begin
          sat = 1'b1;
          s = -64'sd2147483648;
        end
`endif
        return s[31:0];
      end
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {(sb < sa), d[30:0]};
      4'd6: return (sb >= sa) ? b : a;
      4'd7: return (sb >= sa) ? a : b;
      4'd8: return areg[31] ? b : (sl ? fo : 32'h0);
      default: return b;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          base;
    int          csa, csb, cal, n;
    logic        sl, s, seed, dl;
    logic [3:0]  cf;
    logic [31:0] a, b, res;
    exp_t        e;

    vecs[0]  = '{4'd0,  3,  7, 32'd5,          32'hFFFF_FFFE, 32'd3};
    vecs[1]  = '{4'd1,  3,  7, 32'd5,          32'hFFFF_FFFE, 32'hFFFF_FFF9};
    vecs[2]  = '{4'd2,  0,  1, 32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200};
    vecs[3]  = '{4'd3,  0,  1, 32'hF0F0_1234,  32'h0FF0_FF00, 32'hFFF0_FF34};
    vecs[4]  = '{4'd4,  0,  1, 32'hF0F0_1234,  32'h0FF0_FF00, 32'hFF00_ED34};
    vecs[5]  = '{4'd5,  2,  9, 32'd1,          32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6]  = '{4'd5,  2,  9, 32'hFFFF_FFFF,  32'd1,         32'h0000_0002};
    vecs[7]  = '{4'd6,  4, 15, 32'h8000_0000,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[8]  = '{4'd7,  4, 15, 32'h8000_0000,  32'h7FFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{4'd8,  1,  2, 32'h8000_0001,  32'h0000_1234, 32'h0000_1234};
    vecs[10] = '{4'd8,  1,  2, 32'h0000_0001,  32'h0000_1234, 32'h0000_0000};
    vecs[11] = '{4'd12, 6,  8, 32'd9,          32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[12] = '{4'd0,  5,  5, 32'd0,          32'd21,        32'd42};

    // Reset state
    #12;
    check("reset flow_out", flow_out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset overflow", overflow, 0);
    #1 rst_n = 1'b1;
    step();

    // Directed vectors, non-accumulate: pulse exactly two cycles after in_valid
    foreach (vecs[i]) begin
      for (int k = 0; k < N_SRC; k++) set_src(k, $urandom);
      set_src(vecs[i].sa, vecs[i].a);
      set_src(vecs[i].sb, vecs[i].b);
      start_run(vecs[i].f, vecs[i].sa, vecs[i].sb, 1'b0, 16'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d valid+1", i), out_valid, 0);
      step();
      check($sformatf("vec%0d valid+2", i), out_valid, 1);
      check($sformatf("vec%0d result", i), flow_out, vecs[i].exp);
      step();
      check($sformatf("vec%0d valid+3", i), out_valid, 0);
    end

    // Accumulate window of 4 with a gap, then a re-seeded window
    start_run(4'd0, 3, 7, 1'b1, 16'd4);
    base = pulses;
    push(32'd1);
    push(32'd2);
    step();
    push(32'd3);
    push(32'd4);
    repeat (3) step();
    check("acc4 pulses", pulses - base, 1);
    check("acc4 sum", last_val, 32'd10);
    base = pulses;
    repeat (4) push(32'd1);
    repeat (3) step();
    check("acc4 reseed pulses", pulses - base, 1);
    check("acc4 reseed sum", last_val, 32'd4);

    // acc_len=1: every sample seeds and delivers b
    start_run(4'd0, 3, 7, 1'b1, 16'd1);
    base = pulses;
    push(32'd5);
    push(32'd9);
    repeat (2) step();
    check("acc1 pulses", pulses - base, 2);
    check("acc1 value", last_val, 32'd9);

    // acc_len=0: running sum delivered on every sample
    start_run(4'd0, 3, 7, 1'b1, 16'd0);
    base = pulses;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    repeat (2) step();
    check("acc0 pulses", pulses - base, 3);
    check("acc0 value", last_val, 32'd6);

    // Abort mid-window: no delivery, IDLE ignores in_valid, next run starts fresh
    start_run(4'd0, 3, 7, 1'b1, 16'd4);
    base = pulses;
    push(32'd1);
    push(32'd1);
    en = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      step();
      check("abort idle out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("abort pulses", pulses - base, 0);
    en = 1'b1;
    step();
    base = pulses;
    repeat (4) push(32'd1);
    repeat (3) step();
    check("abort rerun pulses", pulses - base, 1);
    check("abort rerun sum", last_val, 32'd4);

    // Signed overflow on ADD, sticky until IDLE
    set_src(3, 32'h7FFF_FFFF);
    set_src(7, 32'd1);
    start_run(4'd0, 3, 7, 1'b0, 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("ovf sum", flow_out, OVF_SUM);
    check("ovf flag", overflow, OVF_FLAG);
    repeat (2) step();
    check("ovf held", overflow, OVF_FLAG);
    en = 1'b0;
    step();
    check("ovf cleared", overflow, 0);
    check("idle holds flow_out", flow_out, OVF_SUM);

    // Reset while running with in_valid high
    set_src(3, 32'd5);
    set_src(7, 32'hFFFF_FFFE);
    start_run(4'd0, 3, 7, 1'b0, 16'd0);
    in_valid = 1'b1;
    step();
    step();
    check("prerst valid", out_valid, 1);
    check("prerst value", flow_out, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst async flow_out", flow_out, 0);
    check("rst async out_valid", out_valid, 0);
    step();
    check("rst edge out_valid", out_valid, 0);
    check("rst edge flow_out", flow_out, 0);
    #2 rst_n = 1'b1;
    step();
    check("rst rel+1 out_valid", out_valid, 0);
    step();
    check("rst rel+2 out_valid", out_valid, 0);
    step();
    check("rst rel+3 out_valid", out_valid, 1);
    check("rst rel+3 value", flow_out, 32'd3);

    // Randomized runs against the sample-level model
    do_reset();
    m_flow = '0;
    m_vis = '0;
    for (int r = 0; r < 8; r++) begin
      sl  = (r % 2) == 1;
      cal = sl ? r / 2 : 0;
      cf  = 4'($urandom_range(0, 15));
      csa = $urandom_range(0, 15);
      csb = $urandom_range(0, 15);
      start_run(cf, csa, csb, sl, 16'(cal));
      m_ovf = 1'b0;
      n = 0;
      for (int i = 0; i < 150; i++) begin
        for (int k = 0; k < N_SRC; k++) set_src(k, $urandom);
        sela = SEL_W'($urandom);
        selb = SEL_W'($urandom);
        fns = 4'($urandom);
        self_loop = 1'($urandom);
        acc_len = 16'($urandom);
        in_valid = (i < 144) && ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          a = flow_in[csa*DATA_W +: DATA_W];
          b = flow_in[csb*DATA_W +: DATA_W];
          seed = sl && (n == 0);
          s = 1'b0;
          if (seed) res = b;
          else      res = ref_op(cf, sl ? m_flow : a, b, a, sl, m_flow, s);
          if (!sl) begin
            dl = 1'b1;
          end else if (cal == 0) begin
            dl = 1'b1;
            n = 1;
          end else begin
            n++;
            dl = (n == cal);
            if (dl) n = 0;
          end
          m_flow = res;
          q.push_back('{due: cyc + 2, vld: dl, val: res, sat: s});
        end
        step();
        if (q.size() != 0 && q[0].due == cyc) begin
          e = q.pop_front();
          m_vis = e.val;
          m_ovf = m_ovf | e.sat;
          check($sformatf("rnd%0d out_valid", r), out_valid, e.vld);
        end else begin
          check($sformatf("rnd%0d quiet out_valid", r), out_valid, 0);
        end
        check($sformatf("rnd%0d flow_out", r), flow_out, m_vis);
        check($sformatf("rnd%0d overflow", r), overflow, m_ovf);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
